// File: rtl/rst_sequencer.sv
// Board-level reset sequencer: synchronizes the button reset and PLL lock, then releases the
// downstream reset domains in order with fixed spacing; handles software reset and lock loss.
module rst_sequencer #(
  parameter int unsigned N_DOMAINS     = 3,
  parameter int unsigned STAGE_DLY     = 16,
  parameter int unsigned LOCK_FILTER   = 8,
  parameter int unsigned SW_RST_CYCLES = 32
) (
  input  logic                 clk,
  input  logic                 RST_n,
  input  logic                 pll_locked,
  input  logic                 sw_rst_req,
  output logic [N_DOMAINS-1:0] rst_n_out,
  output logic                 seq_done,
  output logic [2:0]           state_o
);

  typedef enum logic [2:0] {
    StHold     = 3'd0,
    StWaitLock = 3'd1,
    StRelease  = 3'd2,
    StRun      = 3'd3,
    StSwRst    = 3'd4
  } state_e;

  localparam int unsigned MaxLs  = (STAGE_DLY > LOCK_FILTER) ? STAGE_DLY : LOCK_FILTER;
  localparam int unsigned MaxCnt = (MaxLs > SW_RST_CYCLES) ? MaxLs : SW_RST_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);
  localparam int unsigned IdxW   = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

  localparam logic [CntW-1:0]      LockLast  = CntW'(LOCK_FILTER - 1);
  localparam logic [CntW-1:0]      StageLast = CntW'(STAGE_DLY - 1);
  localparam logic [CntW-1:0]      SwLast    = CntW'(SW_RST_CYCLES - 1);
  localparam logic [IdxW-1:0]      IdxLast   = IdxW'(N_DOMAINS - 1);
  localparam logic [N_DOMAINS-1:0] Dom0      = N_DOMAINS'(1);

  logic rst_ff1_q, rst_sync_q;
  logic plk_ff1_q, plk_q;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [IdxW-1:0] idx_q;

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      rst_ff1_q  <= 1'b0;
      rst_sync_q <= 1'b0;
      plk_ff1_q  <= 1'b0;
      plk_q      <= 1'b0;
    end else begin
      rst_ff1_q  <= 1'b1;
      rst_sync_q <= rst_ff1_q;
      plk_ff1_q  <= pll_locked;
      plk_q      <= plk_ff1_q;
    end
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      state_q   <= StHold;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_n_out <= '0;
      seq_done  <= 1'b0;
    end else begin
      case (state_q)
        StHold: begin
          rst_n_out <= '0;
          seq_done  <= 1'b0;
          if (rst_sync_q) begin
            state_q <= StWaitLock;
            cnt_q   <= '0;
          end
        end

        StWaitLock: begin
          if (!plk_q) begin
            cnt_q <= '0;
          end else if (cnt_q == LockLast) begin
            state_q   <= StRelease;
            rst_n_out <= Dom0;
            cnt_q     <= '0;
            idx_q     <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        StRelease: begin
          if (!plk_q) begin
            state_q   <= StWaitLock;
            rst_n_out <= '0;
            seq_done  <= 1'b0;
            cnt_q     <= '0;
            idx_q     <= '0;
          end else if (cnt_q == StageLast) begin
            cnt_q <= '0;
            if (idx_q == IdxLast) begin
              // Last domain has had its full spacing period; sequence complete.
              state_q  <= StRun;
              seq_done <= 1'b1;
            end else begin
              // Released domains are always a contiguous run starting at bit 0.
              idx_q     <= idx_q + IdxW'(1);
              rst_n_out <= (rst_n_out << 1) | Dom0;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        StRun: begin
          // Lock loss takes priority over a simultaneous software request.
          if (!plk_q) begin
            state_q   <= StWaitLock;
            rst_n_out <= '0;
            seq_done  <= 1'b0;
            cnt_q     <= '0;
            idx_q     <= '0;
          end else if (sw_rst_req) begin
            state_q   <= StSwRst;
            rst_n_out <= '0;
            seq_done  <= 1'b0;
            cnt_q     <= '0;
          end
        end

        StSwRst: begin
          rst_n_out <= '0;
          seq_done  <= 1'b0;
          if (cnt_q == SwLast) begin
            state_q <= StWaitLock;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        default: begin
          state_q   <= StHold;
          rst_n_out <= '0;
          seq_done  <= 1'b0;
          cnt_q     <= '0;
          idx_q     <= '0;
        end
      endcase
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Testbench for rst_sequencer: directed scenarios with literal edge checks plus a per-cycle
// comparison against a time-based behavioural model.
module tb_rst_sequencer;

  localparam int ND = 3;
  localparam int SD = 4;
  localparam int LF = 4;
  localparam int SW = 8;

  logic          clk        = 1'b0;
  logic          RST_n      = 1'b0;
  logic          pll_locked = 1'b1;
  logic          sw_rst_req = 1'b0;
  logic [ND-1:0] rst_n_out;
  logic          seq_done;
  logic [2:0]    state_o;

  int n_checks = 0;
  int n_pass   = 0;

  rst_sequencer #(
    .N_DOMAINS    (ND),
    .STAGE_DLY    (SD),
    .LOCK_FILTER  (LF),
    .SW_RST_CYCLES(SW)
  ) dut (
    .clk       (clk),
    .RST_n     (RST_n),
    .pll_locked(pll_locked),
    .sw_rst_req(sw_rst_req),
    .rst_n_out (rst_n_out),
    .seq_done  (seq_done),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model modes: 0 reset hold, 1 waiting for lock, 2 sequencing/running, 3 software reset.
  int   m_mode = 0, m_since = 0, m_run = 0, m_cyc = 0, m_t0 = 0, m_tsw = 0;
  logic m_pk1 = 1'b0, m_pk2 = 1'b0;
  int   exp_rst = 0, exp_done = 0, exp_state = 0;

  initial begin : model
    logic plk_now;
    int   e, nrel;
    forever begin
      @(posedge clk or negedge RST_n);
      if (!RST_n) begin
        m_mode = 0; m_since = 0; m_run = 0;
        m_pk1 = 1'b0; m_pk2 = 1'b0;
        exp_rst = 0; exp_done = 0; exp_state = 0;
      end else begin
        plk_now = m_pk2;
        m_pk2   = m_pk1;
        m_pk1   = pll_locked;
        m_cyc++;
        case (m_mode)
          0: if (m_since >= 2) begin m_mode = 1; m_run = 0; end
          1: begin
            if (plk_now) begin
              m_run++;
              if (m_run == LF) begin m_mode = 2; m_t0 = m_cyc; end
            end else m_run = 0;
          end
          2: begin
            if (!plk_now) begin m_mode = 1; m_run = 0; end
            else if ((m_cyc - m_t0 > SD * ND) && sw_rst_req) begin m_mode = 3; m_tsw = m_cyc; end
          end
          default: if (m_cyc - m_tsw == SW) begin m_mode = 1; m_run = 0; end
        endcase
        if (m_since < 2) m_since++;
        case (m_mode)
          0: begin exp_rst = 0; exp_done = 0; exp_state = 0; end
          1: begin exp_rst = 0; exp_done = 0; exp_state = 1; end
          2: begin
            e    = m_cyc - m_t0;
            nrel = e / SD + 1;
            if (nrel > ND) nrel = ND;
            exp_rst   = (1 << nrel) - 1;
            exp_done  = (e >= SD * ND) ? 1 : 0;
            exp_state = (e >= SD * ND) ? 3 : 2;
          end
          default: begin exp_rst = 0; exp_done = 0; exp_state = 4; end
        endcase
      end
    end
  end

  initial begin : compare
    forever begin
      @(posedge clk);
      #2;
      chk("model_rst_n_out", int'(rst_n_out), exp_rst);
      chk("model_seq_done", int'(seq_done), exp_done);
      chk("model_state", int'(state_o), exp_state);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Steps until the DUT reaches the wanted state/outputs; want_rst < 0 means don't care.
  task automatic wait_for(input string name, input int want_state, input int want_rst,
                          input int maxc);
    bit hit = 1'b0;
    for (int i = 0; i < maxc && !hit; i++) begin
      step(1);
      if (int'(state_o) == want_state && (want_rst < 0 || int'(rst_n_out) == want_rst))
        hit = 1'b1;
    end
    n_checks++;
    if (hit) n_pass++;
    else $display("FAIL %s: state %0d rst %0d, wanted state %0d within %0d cycles", name,
                  state_o, rst_n_out, want_state, maxc);
  endtask

  // Called with RST_n just released; the next posedge is E0.
  task automatic seq_from_reset(input string tag);
    step(2);
    chk({tag, "_e1_state"}, int'(state_o), 0);
    step(1);
    chk({tag, "_e2_state"}, int'(state_o), 1);
    step(3);
    chk({tag, "_e5_rst"}, int'(rst_n_out), 0);
    step(1);
    chk({tag, "_e6_rst"}, int'(rst_n_out), 1);
    chk({tag, "_e6_state"}, int'(state_o), 2);
    step(3);
    chk({tag, "_e9_rst"}, int'(rst_n_out), 1);
    step(1);
    chk({tag, "_e10_rst"}, int'(rst_n_out), 3);
    step(4);
    chk({tag, "_e14_rst"}, int'(rst_n_out), 7);
    step(3);
    chk({tag, "_e17_done"}, int'(seq_done), 0);
    chk({tag, "_e17_state"}, int'(state_o), 2);
    step(1);
    chk({tag, "_e18_done"}, int'(seq_done), 1);
    chk({tag, "_e18_state"}, int'(state_o), 3);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    step(3);
    chk("reset_rst", int'(rst_n_out), 0);
    chk("reset_done", int'(seq_done), 0);
    chk("reset_state", int'(state_o), 0);

    // Power-up with lock steady.
    RST_n = 1'b1;
    seq_from_reset("s1");

    // Software reset from RUN.
    step(2);
    sw_rst_req = 1'b1;
    step(1);
    sw_rst_req = 1'b0;
    chk("s4_entry_state", int'(state_o), 4);
    chk("s4_entry_rst", int'(rst_n_out), 0);
    chk("s4_entry_done", int'(seq_done), 0);
    step(7);
    chk("s4_last_state", int'(state_o), 4);
    step(1);
    chk("s4_exit_state", int'(state_o), 1);
    step(3);
    chk("s4_pre_rel_rst", int'(rst_n_out), 0);
    step(1);
    chk("s4_rel_rst", int'(rst_n_out), 1);
    wait_for("s4_run", 3, -1, 40);

    // Lock loss and software request seen on the same edge in RUN.
    step(2);
    pll_locked = 1'b0;
    step(2);
    sw_rst_req = 1'b1;
    step(1);
    sw_rst_req = 1'b0;
    chk("s5_both_state", int'(state_o), 1);
    chk("s5_both_rst", int'(rst_n_out), 0);

    // Software request during RELEASE is ignored.
    pll_locked = 1'b1;
    wait_for("s5_release", 2, -1, 40);
    sw_rst_req = 1'b1;
    step(1);
    sw_rst_req = 1'b0;
    chk("s5_rel_sw_state", int'(state_o), 2);
    chk("s5_rel_sw_rst", int'(rst_n_out), 1);

    // Lock loss mid-release with two domains out, then replay.
    wait_for("s3_two_out", 2, 3, 40);
    pll_locked = 1'b0;
    step(2);
    chk("s3_still_rst", int'(rst_n_out), 3);
    step(1);
    chk("s3_abort_rst", int'(rst_n_out), 0);
    chk("s3_abort_state", int'(state_o), 1);
    pll_locked = 1'b1;
    step(5);
    chk("s3_replay_pre_rst", int'(rst_n_out), 0);
    step(1);
    chk("s3_replay_rst", int'(rst_n_out), 1);
    step(4);
    chk("s3_replay_d1_rst", int'(rst_n_out), 3);
    wait_for("s3_run", 3, -1, 40);

    // One-cycle lock glitch after three counted cycles in WAIT_LOCK.
    pll_locked = 1'b0;
    step(6);
    chk("s2_wait_state", int'(state_o), 1);
    pll_locked = 1'b1;
    step(3);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    step(2);
    chk("s2_glitch_rst", int'(rst_n_out), 0);
    chk("s2_glitch_state", int'(state_o), 1);
    step(3);
    chk("s2_late_rst", int'(rst_n_out), 0);
    step(1);
    chk("s2_release_rst", int'(rst_n_out), 1);

    // Asynchronous reset pulse between edges in RELEASE.
    step(1);
    #1 RST_n = 1'b0;
    #1;
    chk("s6_async_rst", int'(rst_n_out), 0);
    chk("s6_async_state", int'(state_o), 0);
    chk("s6_async_done", int'(seq_done), 0);
    #1 RST_n = 1'b1;
    seq_from_reset("s6");

    step(5);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
